fetch_stall_ctrl: RTL
=====================

Name: fetch_stall_ctrl

Overview:
Front-end pipeline controller that acts on the stall requests from the hazard unit. It owns the PC register, the IF/ID pipeline register and the control-field half of the ID/EX register. It applies hold, bubble and flush actions cycle by cycle. It also runs a stall-tracking FSM that flags runaway stalls and inconsistent stall-request combinations.

Parameters:
PC_W, 16, PC width (word-addressed)
INSTR_W, 16, instruction width
CTRL_W, 8, ID/EX control bundle width
RESET_PC, 0, PC value after reset
MAX_STALL, 4, consecutive stall cycles before timeout is flagged (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
pcWrite  input  1  1 = advance PC, 0 = hold PC
IFID_write  input  1  1 = load IF/ID, 0 = hold IF/ID
handlerSel  input  1  1 = pass ctrl_in to ID/EX, 0 = insert bubble
branch_taken  input  1  branch resolved taken this cycle; flush
branch_target  input  PC_W  PC to load when branch_taken
instr_in  input  INSTR_W  instruction memory data at address pc
ctrl_in  input  CTRL_W  decoded control for instruction in IF/ID
pc  output  PC_W  current fetch address
ifid_instr  output  INSTR_W  IF/ID instruction
ifid_pc1  output  PC_W  IF/ID pc+1
ifid_valid  output  1  IF/ID holds a real instruction
idex_ctrl  output  CTRL_W  ID/EX control bundle
idex_valid  output  1  ID/EX holds a real instruction
stalling  output  1  FSM in STALL or TIMEOUT
stall_timeout  output  1  sticky; stall run reached MAX_STALL
req_err  output  1  sticky; inconsistent stall request seen

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; ifid_instr=0 (NOP); ifid_pc1=0; ifid_valid=0; idex_ctrl=0; idex_valid=0; FSM=RUN; stall_run=0; stall_timeout=0; req_err=0. Reset overrides all inputs. Reset mid-stall fully clears the stall state.
- PC: priority is branch_taken > pcWrite. If branch_taken, pc<=branch_target. Else if pcWrite, pc<=pc+1, wrapping mod 2^PC_W (all-ones -> 0). Else hold.
- IF/ID on branch_taken: flush, so ifid_instr<=0, ifid_valid<=0, ifid_pc1 holds.
- IF/ID on IFID_write (no branch_taken): ifid_instr<=instr_in, ifid_pc1<=pc+1 (wrapping), ifid_valid<=1.
- IF/ID otherwise: hold.
- ID/EX on branch_taken or handlerSel=0: idex_ctrl<=0, idex_valid<=0.
- ID/EX otherwise: idex_ctrl<=ctrl_in, idex_valid<=ifid_valid.
- Latency: instr_in sampled at edge N appears on ifid_instr after N. Its ctrl reaches idex_ctrl one edge later when not stalled.
- stall_req = pcWrite==0 && IFID_write==0 && handlerSel==0.
- Stall request consistency: pcWrite, IFID_write and handlerSel must be equal. Any mismatch while branch_taken=0 sets req_err (sticky). Datapath still obeys each signal individually.
- FSM RUN: if stall_req && !branch_taken, go to STALL with stall_run<=1.
- FSM STALL: while stall_req && !branch_taken, stall_run++. When stall_run would reach MAX_STALL, go to TIMEOUT and set stall_timeout. Otherwise go to RUN with stall_run<=0.
- FSM TIMEOUT: same exit rule as STALL. stall_run saturates at MAX_STALL. stall_timeout stays 1 until rst.
- stalling = (FSM != RUN), registered.
- branch_taken coincident with a stall request: the flush wins for PC, IF/ID and ID/EX. The FSM treats that cycle as non-stall.

Optional Feature:
- Macro STALL_STATS_EN.
- Defined: adds output stall_total[15:0], a count of cycles with stall_req && !branch_taken. It saturates at 16'hFFFF, reset to 0 by rst, and adds output flush_total[15:0], counting branch_taken cycles with the same saturation and reset.
- Undefined: neither port nor counters exist. All other behaviour is identical.

Test Plan:
- Reset then 3 cycles with all write/sel=1 and instr_in=0x1111, 0x2222, 0x3333 -> pc 0,1,2,3. ifid_instr tracks one cycle behind with ifid_valid=1. idex_valid=1 from cycle 3.
- One-cycle stall (all three =0) with ctrl_in=0xA5 -> pc and ifid_instr hold, idex_ctrl=0, idex_valid=0, stalling=1 for one cycle. Resume matches the no-stall sequence shifted by 1.
- 4 consecutive stall cycles with MAX_STALL=4 -> stall_timeout=1 after the 4th edge and stays 1 after resume until rst.
- branch_taken=1 with branch_target=0x0040 during a stall -> pc=0x0040, ifid_valid=0, idex_valid=0, FSM=RUN.
- pc=0xFFFF, pcWrite=1 -> pc=0x0000, ifid_pc1=0x0000.
- pcWrite=1, IFID_write=0, handlerSel=1 -> req_err=1 and stays 1. pc advances while IF/ID holds.

Source files
------------

// File: rtl/fetch_stall_ctrl.sv
// Front-end stall/flush controller: PC, IF/ID and ID/EX control registers plus stall-tracking FSM.
// Optional STALL_STATS_EN macro adds saturating stall_total / flush_total counters.
module fetch_stall_ctrl #(
  parameter int              PC_W      = 16,
  parameter int              INSTR_W   = 16,
  parameter int              CTRL_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              MAX_STALL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pcWrite,
  input  logic               IFID_write,
  input  logic               handlerSel,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc1,
  output logic               ifid_valid,
  output logic [CTRL_W-1:0]  idex_ctrl,
  output logic               idex_valid,
  output logic               stalling,
  output logic               stall_timeout,
`ifdef STALL_STATS_EN
  output logic [15:0]        stall_total,
  output logic [15:0]        flush_total,
`endif
  output logic               req_err
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_STALL);

  typedef enum logic [1:0] {RUN, STALL, TIMEOUT} state_t;

  state_t           state;
  logic [RUN_W-1:0] stall_run;
  logic [PC_W-1:0]  pc_inc;
  logic [RUN_W-1:0] run_inc;
  logic             stall_req;
  logic             stall_cycle;
  logic             req_mismatch;

  assign pc_inc       = pc + PC_W'(1);
  assign run_inc      = stall_run + RUN_W'(1);
  assign stall_req    = !pcWrite && !IFID_write && !handlerSel;
  assign stall_cycle  = stall_req && !branch_taken;
  assign req_mismatch = (pcWrite != IFID_write) || (IFID_write != handlerSel);

  // Datapath registers: a taken branch flushes everything and beats any hold request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      ifid_instr <= '0;
      ifid_pc1   <= '0;
      ifid_valid <= 1'b0;
      idex_ctrl  <= '0;
      idex_valid <= 1'b0;
    end else begin
      if (branch_taken)
        pc <= branch_target;
      else if (pcWrite)
        pc <= pc_inc;

      if (branch_taken) begin
        ifid_instr <= '0;
        ifid_valid <= 1'b0;
      end else if (IFID_write) begin
        ifid_instr <= instr_in;
        ifid_pc1   <= pc_inc;
        ifid_valid <= 1'b1;
      end

      if (branch_taken || !handlerSel) begin
        idex_ctrl  <= '0;
        idex_valid <= 1'b0;
      end else begin
        idex_ctrl  <= ctrl_in;
        idex_valid <= ifid_valid;
      end
    end
  end

  // Stall tracker; a flush cycle counts as a non-stall cycle and returns to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      stall_run     <= '0;
      stalling      <= 1'b0;
      stall_timeout <= 1'b0;
      req_err       <= 1'b0;
    end else begin
      if (req_mismatch && !branch_taken)
        req_err <= 1'b1;

      if (!stall_cycle) begin
        state     <= RUN;
        stall_run <= '0;
        stalling  <= 1'b0;
      end else begin
        stalling <= 1'b1;
        case (state)
          RUN: begin
            stall_run <= RUN_W'(1);
            if (RUN_W'(1) >= MAX_RUN) begin
              state         <= TIMEOUT;
              stall_timeout <= 1'b1;
            end else begin
              state <= STALL;
            end
          end
          STALL: begin
            stall_run <= run_inc;
            if (run_inc >= MAX_RUN) begin
              state         <= TIMEOUT;
              stall_timeout <= 1'b1;
            end
          end
          default: begin
            state     <= TIMEOUT;
            stall_run <= MAX_RUN;
          end
        endcase
      end
    end
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_total <= '0;
      flush_total <= '0;
    end else begin
      if (stall_cycle && stall_total != 16'hFFFF)
        stall_total <= stall_total + 16'd1;
      if (branch_taken && flush_total != 16'hFFFF)
        flush_total <= flush_total + 16'd1;
    end
  end
`endif

endmodule
